// File: rtl/cdc_cmd_arbiter.sv
//------------------------------------------------------------------------------
// cdc_cmd_arbiter
//
// Round-robin arbiter that accepts command words from N requesters in the
// src_clk domain and delivers one word at a time into the dst_clk domain.
// The crossing uses a toggle handshake. A single-bit request level goes to
// dst_clk and a single-bit ack level comes back to src_clk. Each level passes
// through a 3-flop synchronizer. The multi-bit command word stays in a source
// hold register. The hold register does not change while a transfer is in
// flight, so the destination samples it only when it is stable.
//
// Ports
//   src_clk   in   source-domain clock
//   reset_n   in   asynchronous active-low reset for both domains
//   dst_clk   in   destination-domain clock, unrelated to src_clk
//   req       in   [N]        per-requester request level (src_clk)
//   req_data  in   [N*WIDTH]  requester i at bits [i*WIDTH +: WIDTH]
//   done      out  [N]        one src_clk pulse to the winner on completion
//   busy      out             high while a transfer is in flight (src_clk)
//   dst_valid out             one dst_clk pulse when dst_data is new
//   dst_data  out  [WIDTH]    delivered command word (dst_clk)
//------------------------------------------------------------------------------
module cdc_cmd_arbiter #(
    parameter int unsigned N     = 4,
    parameter int unsigned WIDTH = 32
) (
    input  logic               src_clk,
    input  logic               reset_n,
    input  logic               dst_clk,
    input  logic [N-1:0]       req,
    input  logic [N*WIDTH-1:0] req_data,
    output logic [N-1:0]       done,
    output logic               busy,
    output logic               dst_valid,
    output logic [WIDTH-1:0]   dst_data
);

    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1;

    typedef enum logic {
        IDLE     = 1'b0,
        WAIT_ACK = 1'b1
    } state_t;

    // ---------------- src_clk domain state ----------------
    state_t           state_q,    state_d;
    logic [IW-1:0]    win_q,      win_d;
    logic [WIDTH-1:0] hold_q,     hold_d;
    logic             req_tgl_q,  req_tgl_d;
    logic [2:0]       ack_sync_q, ack_sync_d;
    logic             ack_seen_q, ack_seen_d;
    logic [N-1:0]     done_q,     done_d;
    logic             busy_q,     busy_d;

    // ---------------- dst_clk domain state ----------------
    logic [2:0]       req_sync_q,  req_sync_d;
    logic             ack_tgl_q,   ack_tgl_d;
    logic             dst_valid_q, dst_valid_d;
    logic [WIDTH-1:0] dst_data_q,  dst_data_d;

    logic [WIDTH-1:0] req_words [N];
    logic [IW-1:0]    pick;
    logic             pick_vld;
    logic             ack_edge;

    for (genvar g = 0; g < N; g++) begin : g_split
        assign req_words[g] = req_data[g*WIDTH +: WIDTH];
    end

    // Round-robin search starting one past the last winner, wrapping at N.
    always_comb begin : rr_search
        int unsigned cand;
        cand     = 0;
        pick     = win_q;
        pick_vld = 1'b0;
        for (int unsigned i = 1; i <= N; i++) begin
            cand = (32'(win_q) + i) % N;
            if (!pick_vld && req[IW'(cand)]) begin
                pick     = IW'(cand);
                pick_vld = 1'b1;
            end
        end
    end

    // Ack edge: the synchronized ack level differs from the last value seen.
    assign ack_edge = ack_sync_q[2] ^ ack_seen_q;

    always_comb begin : src_next
        state_d    = state_q;
        win_d      = win_q;
        hold_d     = hold_q;
        req_tgl_d  = req_tgl_q;
        ack_sync_d = {ack_sync_q[1:0], ack_tgl_q};
        ack_seen_d = ack_sync_q[2];
        done_d     = '0;
        busy_d     = busy_q;
        case (state_q)
            IDLE: begin
                if (pick_vld) begin
                    win_d     = pick;
                    hold_d    = req_words[pick];
                    req_tgl_d = ~req_tgl_q;
                    busy_d    = 1'b1;
                    state_d   = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                // req is ignored here; only the returning ack ends the transfer.
                if (ack_edge) begin
                    done_d[win_q] = 1'b1;
                    busy_d        = 1'b0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge src_clk or negedge reset_n) begin : src_regs
        if (!reset_n) begin
            state_q    <= IDLE;
            win_q      <= IW'(N - 1);
            hold_q     <= '0;
            req_tgl_q  <= 1'b0;
            ack_sync_q <= '0;
            ack_seen_q <= 1'b0;
            done_q     <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            win_q      <= win_d;
            hold_q     <= hold_d;
            req_tgl_q  <= req_tgl_d;
            ack_sync_q <= ack_sync_d;
            ack_seen_q <= ack_seen_d;
            done_q     <= done_d;
            busy_q     <= busy_d;
        end
    end

    // The ack level follows the synchronized request level. A mismatch between
    // them marks a new request, so the ack flop also works as the edge
    // detector's history bit.
    always_comb begin : dst_next
        req_sync_d  = {req_sync_q[1:0], req_tgl_q};
        dst_valid_d = req_sync_q[2] ^ ack_tgl_q;
        ack_tgl_d   = req_sync_q[2];
        dst_data_d  = dst_valid_d ? hold_q : dst_data_q;
    end

    always_ff @(posedge dst_clk or negedge reset_n) begin : dst_regs
        if (!reset_n) begin
            req_sync_q  <= '0;
            ack_tgl_q   <= 1'b0;
            dst_valid_q <= 1'b0;
            dst_data_q  <= '0;
        end else begin
            req_sync_q  <= req_sync_d;
            ack_tgl_q   <= ack_tgl_d;
            dst_valid_q <= dst_valid_d;
            dst_data_q  <= dst_data_d;
        end
    end

    assign done      = done_q;
    assign busy      = busy_q;
    assign dst_valid = dst_valid_q;
    assign dst_data  = dst_data_q;

endmodule

// File: tb/tb_cdc_cmd_arbiter.sv
//------------------------------------------------------------------------------
// tb_cdc_cmd_arbiter
//
// Self-checking bench for cdc_cmd_arbiter with a 100 MHz src_clk and a
// 33 MHz dst_clk. The two clocks are phase-offset so their edges never
// coincide. A reference model keeps the round-robin pointer and predicts the
// winner, the delivered word and the done vector for each transfer.
//------------------------------------------------------------------------------
module tb_cdc_cmd_arbiter;

    localparam int N = 4;
    localparam int W = 32;

    logic             src_clk;
    logic             dst_clk;
    logic             reset_n;
    logic [N-1:0]     req;
    logic [N*W-1:0]   req_data;
    logic [N-1:0]     done;
    logic             busy;
    logic             dst_valid;
    logic [W-1:0]     dst_data;

    int checks = 0;
    int errors = 0;

    cdc_cmd_arbiter #(.N(N), .WIDTH(W)) dut (
        .src_clk   (src_clk),
        .reset_n   (reset_n),
        .dst_clk   (dst_clk),
        .req       (req),
        .req_data  (req_data),
        .done      (done),
        .busy      (busy),
        .dst_valid (dst_valid),
        .dst_data  (dst_data)
    );

    initial begin
        src_clk = 1'b0;
        forever #5 src_clk = ~src_clk;
    end

    initial begin
        dst_clk = 1'b0;
        #2;
        forever #15 dst_clk = ~dst_clk;
    end

    // ---------------- passive monitors ----------------
    int unsigned src_edges     = 0;
    int unsigned dst_edges     = 0;
    int unsigned src_at_dst    = 0;
    int unsigned dst_total     = 0;
    int unsigned done_total    = 0;
    int unsigned multi_done    = 0;
    logic [W-1:0] dst_last_data = '0;
    int unsigned dst_last_edge = 0;
    int unsigned dst_last_snap = 0;

    always @(posedge src_clk) src_edges <= src_edges + 1;

    always @(posedge dst_clk) begin
        dst_edges  <= dst_edges + 1;
        src_at_dst <= src_edges;
    end

    always @(negedge dst_clk) begin
        if (dst_valid === 1'b1) begin
            dst_total     <= dst_total + 1;
            dst_last_data <= dst_data;
            dst_last_edge <= dst_edges;
            dst_last_snap <= src_at_dst;
        end
    end

    always @(negedge src_clk) begin
        if (done !== '0) begin
            done_total <= done_total + 1;
            if ($countones(done) != 1) multi_done <= multi_done + 1;
        end
    end

    // ---------------- reference model ----------------
    int unsigned m_ptr;

    function automatic int unsigned rr_pick(input int unsigned ptr, input logic [N-1:0] r);
        for (int unsigned k = 1; k <= N; k++) begin
            if (r[(ptr + k) % N]) return (ptr + k) % N;
        end
        return ptr;
    endfunction

    function automatic logic [N*W-1:0] rand_words();
        logic [N*W-1:0] d;
        for (int i = 0; i < N; i++) d[i*W +: W] = $urandom;
        return d;
    endfunction

    // ---------------- transaction driver (observes, does not judge) ----------
    bit           r_to;
    int unsigned  r_dcnt;
    logic [W-1:0] r_ddata;
    int unsigned  r_dlat;
    logic [N-1:0] r_dv;
    int unsigned  r_dnlat;
    bit           r_busy_ok;
    logic         r_busy_after;

    // Called at a src_clk negedge with the FSM idle; returns at the negedge
    // where done is seen.
    task automatic run_txn(input logic [N-1:0] r, input logic [N*W-1:0] d,
                           input bit scramble, input bit pulse_only);
        int unsigned dst_base;
        int unsigned sel_edges;
        dst_base = dst_total;
        req      = r;
        req_data = d;
        @(posedge src_clk);
        sel_edges = dst_edges;
        @(negedge src_clk);
        r_busy_ok = (busy === 1'b1);
        if (pulse_only) req = '0;
        r_to = 1'b1;
        r_dv = '0;
        for (int c = 0; c < 300; c++) begin
            if (done !== '0) begin
                r_dv = done;
                r_to = 1'b0;
                break;
            end
            if (busy !== 1'b1) r_busy_ok = 1'b0;
            if (scramble) begin
                req      = N'($urandom);
                req_data = rand_words();
            end
            @(negedge src_clk);
        end
        r_busy_after = busy;
        r_dcnt  = dst_total - dst_base;
        r_ddata = dst_last_data;
        r_dlat  = dst_last_edge - sel_edges;
        r_dnlat = src_edges - dst_last_snap;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset_n  = 1'b0;
        req      = '0;
        req_data = '0;
        repeat (3) @(negedge src_clk);
        checks++; if (done !== '0) begin errors++; $display("FAIL reset_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b expected 0", busy); end
        checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL reset_dst_valid: got %b expected 0", dst_valid); end
        checks++; if (dst_data !== '0) begin errors++; $display("FAIL reset_dst_data: got %h expected 0", dst_data); end
        reset_n = 1'b1;
        m_ptr   = N - 1;
        repeat (4) @(negedge src_clk);
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL idle_busy: got %b expected 0", busy); end
    endtask

    task automatic test_single();
        logic [N*W-1:0] d;
        d = rand_words();
        d[2*W +: W] = 32'hDEADBEEF;
        run_txn(4'b0100, d, 1'b0, 1'b0);
        req = '0;
        m_ptr = rr_pick(m_ptr, 4'b0100);
        checks++; if (r_to) begin errors++; $display("FAIL single_timeout: got timeout expected done"); end
        checks++; if (r_dcnt != 1) begin errors++; $display("FAIL single_dst_count: got %0d expected 1", r_dcnt); end
        checks++; if (r_ddata !== 32'hDEADBEEF) begin errors++; $display("FAIL single_dst_data: got %h expected deadbeef", r_ddata); end
        checks++; if (r_dv !== 4'b0100) begin errors++; $display("FAIL single_done: got %b expected 0100", r_dv); end
        checks++; if (!r_busy_ok) begin errors++; $display("FAIL single_busy: got low expected high in flight"); end
        checks++; if (r_busy_after !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b expected 0", r_busy_after); end
        repeat (20) @(negedge src_clk);
        checks++; if (dst_data !== 32'hDEADBEEF) begin errors++; $display("FAIL single_hold: got %h expected deadbeef", dst_data); end
    endtask

    task automatic test_latency();
        run_txn(4'b0001, rand_words(), 1'b0, 1'b0);
        req = '0;
        m_ptr = rr_pick(m_ptr, 4'b0001);
        checks++; if (r_dlat != 4) begin errors++; $display("FAIL lat_dst: got %0d edges expected 4", r_dlat); end
        checks++; if (!(r_dnlat inside {4, 5})) begin errors++; $display("FAIL lat_done: got %0d edges expected 4..5", r_dnlat); end
        repeat (5) @(negedge src_clk);
    endtask

    task automatic test_round_robin();
        logic [N*W-1:0] d;
        int unsigned exp_i;
        reset_n = 1'b0;
        repeat (2) @(negedge src_clk);
        reset_n = 1'b1;
        m_ptr = N - 1;
        @(negedge src_clk);
        for (int i = 0; i < N; i++) d[i*W +: W] = 32'hA000_0000 + 32'(i * 17 + 3);
        for (int k = 0; k < 6; k++) begin
            run_txn(4'b1111, d, 1'b0, 1'b0);
            exp_i = rr_pick(m_ptr, 4'b1111);
            m_ptr = exp_i;
            checks++; if (r_dv !== (N'(1) << (k % N))) begin errors++; $display("FAIL rr_done_%0d: got %b expected %b", k, r_dv, N'(1) << (k % N)); end
            checks++; if (r_ddata !== d[(k % N)*W +: W]) begin errors++; $display("FAIL rr_data_%0d: got %h expected %h", k, r_ddata, d[(k % N)*W +: W]); end
            checks++; if (r_dv !== (N'(1) << exp_i)) begin errors++; $display("FAIL rr_model_%0d: got %b expected %b", k, r_dv, N'(1) << exp_i); end
        end
        req = '0;
        repeat (5) @(negedge src_clk);
    endtask

    task automatic test_stability();
        logic [N*W-1:0] d;
        int unsigned w;
        d = rand_words();
        w = rr_pick(m_ptr, 4'b1010);
        run_txn(4'b1010, d, 1'b1, 1'b0);
        req = '0;
        m_ptr = w;
        checks++; if (r_ddata !== d[w*W +: W]) begin errors++; $display("FAIL stable_data: got %h expected %h", r_ddata, d[w*W +: W]); end
        checks++; if (r_dv !== (N'(1) << w)) begin errors++; $display("FAIL stable_done: got %b expected %b", r_dv, N'(1) << w); end
        checks++; if (r_dcnt != 1) begin errors++; $display("FAIL stable_count: got %0d expected 1", r_dcnt); end
        repeat (5) @(negedge src_clk);
    endtask

    task automatic test_early_drop();
        logic [N*W-1:0] d;
        int unsigned base_dst;
        int unsigned base_done;
        d = rand_words();
        run_txn(4'b0010, d, 1'b0, 1'b1);
        m_ptr = rr_pick(m_ptr, 4'b0010);
        base_dst  = dst_total;
        base_done = done_total;
        checks++; if (r_dv !== 4'b0010) begin errors++; $display("FAIL drop_done: got %b expected 0010", r_dv); end
        checks++; if (r_ddata !== d[1*W +: W]) begin errors++; $display("FAIL drop_data: got %h expected %h", r_ddata, d[1*W +: W]); end
        repeat (60) @(negedge src_clk);
        checks++; if (dst_total != base_dst) begin errors++; $display("FAIL drop_extra_dst: got %0d expected %0d", dst_total, base_dst); end
        checks++; if (done_total != base_done + 1) begin errors++; $display("FAIL drop_extra_done: got %0d expected %0d", done_total, base_done + 1); end
    endtask

    task automatic test_midflight_reset();
        logic [N*W-1:0] d;
        int unsigned base_dst;
        int unsigned base_done;
        base_dst  = dst_total;
        base_done = done_total;
        req      = 4'b1000;
        req_data = rand_words();
        @(posedge src_clk);
        @(posedge src_clk);
        @(posedge src_clk);
        #2;
        checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_busy: got %b expected 1", busy); end
        reset_n = 1'b0;
        req     = '0;
        #1;
        checks++; if (done !== '0) begin errors++; $display("FAIL mid_rst_done: got %b expected 0", done); end
        checks++; if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b expected 0", busy); end
        checks++; if (dst_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_valid: got %b expected 0", dst_valid); end
        checks++; if (dst_data !== '0) begin errors++; $display("FAIL mid_rst_data: got %h expected 0", dst_data); end
        repeat (3) @(negedge src_clk);
        reset_n = 1'b1;
        m_ptr = N - 1;
        repeat (80) @(negedge src_clk);
        checks++; if (dst_total != base_dst) begin errors++; $display("FAIL mid_spurious_dst: got %0d expected %0d", dst_total, base_dst); end
        checks++; if (done_total != base_done) begin errors++; $display("FAIL mid_spurious_done: got %0d expected %0d", done_total, base_done); end
        d = rand_words();
        run_txn(4'b0100, d, 1'b0, 1'b0);
        req = '0;
        m_ptr = rr_pick(m_ptr, 4'b0100);
        checks++; if (r_dv !== 4'b0100) begin errors++; $display("FAIL mid_after_done: got %b expected 0100", r_dv); end
        checks++; if (r_ddata !== d[2*W +: W]) begin errors++; $display("FAIL mid_after_data: got %h expected %h", r_ddata, d[2*W +: W]); end
        repeat (5) @(negedge src_clk);
    endtask

    task automatic test_random();
        logic [N*W-1:0] d;
        logic [N-1:0]   r;
        int unsigned    w;
        for (int k = 0; k < 30; k++) begin
            r = N'($urandom_range(1, (1 << N) - 1));
            d = rand_words();
            w = rr_pick(m_ptr, r);
            run_txn(r, d, 1'($urandom_range(0, 1)), 1'b0);
            m_ptr = w;
            checks++; if (r_to || r_dv !== (N'(1) << w)) begin errors++; $display("FAIL rand_done_%0d: got %b expected %b (req %b)", k, r_dv, N'(1) << w, r); end
            checks++; if (r_dcnt != 1 || r_ddata !== d[w*W +: W]) begin errors++; $display("FAIL rand_data_%0d: got %h x%0d expected %h x1", k, r_ddata, r_dcnt, d[w*W +: W]); end
            checks++; if (r_dlat != 4) begin errors++; $display("FAIL rand_lat_%0d: got %0d expected 4", k, r_dlat); end
        end
        req = '0;
        repeat (5) @(negedge src_clk);
        checks++; if (multi_done != 0) begin errors++; $display("FAIL done_onehot: got %0d multi-bit cycles expected 0", multi_done); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_latency();
        test_round_robin();
        test_stability();
        test_early_drop();
        test_midflight_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/cdc_cmd_arbiter.md
CDC_CMD_ARBITER -- requirements
Module: cdc_cmd_arbiter

Interface
REQ-001 Parameter: N, 4, number of src_clk-domain requesters (2..8).
REQ-002 Parameter: WIDTH, 32, command word width in bits.
REQ-003 Port: src_clk  input  1  source-domain clock.
REQ-004 Port: reset_n  input  1  reset, asynchronous, active-low; resets both domains.
REQ-005 Port: dst_clk  input  1  destination-domain clock, unrelated to src_clk.
REQ-006 Port: req  input  N  per-requester command request level, src_clk domain.
REQ-007 Port: req_data  input  N*WIDTH  per-requester command word; requester i occupies bits [i*WIDTH +: WIDTH].
REQ-008 Port: done  output  N  one-cycle src_clk pulse to the granted requester when its transfer is acknowledged.
REQ-009 Port: busy  output  1  src_clk domain; high while a transfer is in flight.
REQ-010 Port: dst_valid  output  1  one-cycle dst_clk pulse; dst_data is new.
REQ-011 Port: dst_data  output  WIDTH  delivered command word, registered in dst_clk domain.

Function
REQ-012 Source FSM SHALL have states IDLE and WAIT_ACK.
REQ-013 In IDLE with any req bit high, the FSM SHALL select one requester round-robin, searching upward from (last winner + 1) mod N, wrapping.
REQ-014 On selection, the block SHALL latch the winner's req_data into a src-domain hold register, latch the winner index, toggle a src request level, and enter WAIT_ACK on the same edge.
REQ-015 The hold register SHALL remain unchanged from selection until the FSM returns to IDLE.
REQ-016 The src request level SHALL pass through a 3-flop dst_clk synchronizer; an edge detect on the synchronizer output SHALL produce dst_valid.
REQ-017 dst_valid SHALL assert on the 4th dst_clk rising edge after the src request level changes, for exactly one dst_clk cycle.
REQ-018 dst_data SHALL load from the hold register on the same dst_clk edge that asserts dst_valid; otherwise hold.
REQ-019 On the dst_valid edge, the dst domain SHALL toggle an ack level.
REQ-020 The ack level SHALL pass through a 3-flop src_clk synchronizer; its edge SHALL pulse done[winner] for one src_clk cycle and return the FSM to IDLE.
REQ-021 done bits other than the winner's SHALL remain low; at most one done bit SHALL be high in any cycle.
REQ-022 busy SHALL be high exactly while the FSM is in WAIT_ACK.
REQ-023 In WAIT_ACK, req changes SHALL be ignored; deassertion of the winner's req SHALL NOT abort the transfer, and done SHALL still pulse.
REQ-024 After done, at least one IDLE cycle SHALL elapse before the next selection; a requester still high after its done SHALL be treated as a new request.
REQ-025 Winner pointer reset value SHALL be N-1, so requester 0 has first priority.
REQ-026 Only single-bit toggle levels SHALL cross domains; the multi-bit hold register SHALL be sampled only when stable per REQ-015.

Reset
REQ-027 On reset_n low: FSM=IDLE, both toggle levels and all synchronizer flops=0, winner pointer=N-1, hold register=0.
REQ-028 On reset_n low: done=0, busy=0, dst_valid=0, dst_data=0.
REQ-029 Reset during WAIT_ACK SHALL discard the in-flight transfer; no done or dst_valid SHALL be produced for it after release.

Verification
REQ-030 Single request: req=4'b0100, req_data[2]=32'hDEADBEEF -> one dst_valid with dst_data=32'hDEADBEEF; then one done=4'b0100 pulse; busy high across the interval.
REQ-031 Simultaneous requests: req=4'b1111 held, all words distinct -> dst_data order 0,1,2,3,0,...; each done matches the delivered index.
REQ-032 Latency: src_clk 100 MHz, dst_clk 33 MHz -> dst_valid on 4th dst_clk edge after the src toggle; done on the 4th src_clk edge after the ack toggle (+1 for the done register).
REQ-033 Stability: change req_data[winner] every cycle during WAIT_ACK -> dst_data equals the value latched at selection.
REQ-034 Early drop: req[1] pulsed for one cycle -> transfer completes; done[1] pulses once; no second transfer.
REQ-035 Mid-flight reset: assert reset_n low 2 src_clk cycles after selection -> all outputs 0; after release, no spurious dst_valid or done; next request transfers normally.
